// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// Module : fetch_queue_pkg
// Brief  : Shared constants and helpers for the instruction-fetch front end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

  localparam int unsigned c_ADDR_W     = 32;
  localparam int unsigned c_INST_W     = 32;
  localparam int unsigned c_DEPTH      = 4;
  localparam int unsigned c_INST_BYTES = 4;
  localparam int unsigned c_RESET_ADDR = 0;

  // Pointer width for a power-of-two FIFO depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Brief  : Synchronous FIFO of {address, instruction} with flush and head view.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH  = c_DEPTH,
  parameter  int unsigned ADDR_W = c_ADDR_W,
  parameter  int unsigned INST_W = c_INST_W,
  localparam int unsigned PTR_W  = ptr_w(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [INST_W-1:0] i_push_inst,
  input  logic              i_pop,
  output logic [CNT_W-1:0]  o_count,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [INST_W-1:0] o_head_inst
);

  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_full;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign o_count     = r_count;
  assign o_head_addr = r_addr_mem[r_rd_ptr];
  assign o_head_inst = r_inst_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (rst && !i_flush && i_push) begin
      r_addr_mem[r_wr_ptr] <= i_push_addr;
      r_inst_mem[r_wr_ptr] <= i_push_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !i_flush && i_push) begin
      assert (!w_full);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Brief  : Fetch front end: PC, one-read-per-cycle issue, response FIFO and
//          branch flush. FETCH_PERF_EN adds fetched/flushed counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned ADDR_W     = c_ADDR_W,
  parameter int unsigned INST_W     = c_INST_W,
  parameter int unsigned DEPTH      = c_DEPTH,
  parameter int unsigned INST_BYTES = c_INST_BYTES,
  parameter int unsigned RESET_ADDR = c_RESET_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] baddr_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [INST_W-1:0] inst_i,
  output logic              v_o,
  input  logic              stall_i,
  output logic [ADDR_W-1:0] origaddr_o,
  output logic [INST_W-1:0] inst_o
`ifdef FETCH_PERF_EN
 ,output logic [31:0]       fetched_cnt_o,
  output logic [31:0]       flushed_cnt_o
`endif
);

  localparam int unsigned c_PTR_W = ptr_w(DEPTH);
  localparam int unsigned c_CNT_W = c_PTR_W + 1;

  logic [ADDR_W-1:0]  r_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_req_addr;
  logic [c_CNT_W-1:0] w_count;
  logic [c_CNT_W-1:0] w_occ;
  logic               w_push;
  logic               w_pop;

  // Outstanding words (buffered + in flight) bound issue so a push never overflows.
  assign w_occ  = w_count + c_CNT_W'(r_inflight);
  assign req_o  = rst & (branch_i | (w_occ < c_CNT_W'(DEPTH)));
  assign addr_o = branch_i ? baddr_i : r_pc;
  assign w_push = r_inflight & ~branch_i;
  assign v_o    = (w_count != '0);
  assign w_pop  = v_o & ~stall_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= ADDR_W'(RESET_ADDR);
      r_inflight <= 1'b0;
      r_req_addr <= '0;
    end else if (req_o) begin
      r_pc       <= addr_o + ADDR_W'(INST_BYTES);
      r_inflight <= 1'b1;
      r_req_addr <= addr_o;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (branch_i),
    .i_push      (w_push),
    .i_push_addr (r_req_addr),
    .i_push_inst (inst_i),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_addr (origaddr_o),
    .o_head_inst (inst_o)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetched_cnt;
  logic [31:0] r_flushed_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetched_cnt <= '0;
      r_flushed_cnt <= '0;
    end else begin
      if (w_pop)    r_fetched_cnt <= r_fetched_cnt + 32'd1;
      if (branch_i) r_flushed_cnt <= r_flushed_cnt + 32'(w_occ);
    end
  end

  assign fetched_cnt_o = r_fetched_cnt;
  assign flushed_cnt_o = r_flushed_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module : tb_fetch_queue
// Brief  : Directed self-checking bench for fetch_queue (memory returns word = addr).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_i;
    logic [31:0] baddr_i;
    logic        req_o;
    logic [31:0] addr_o;
    logic [31:0] inst_i;
    logic        v_o;
    logic        stall_i;
    logic [31:0] origaddr_o;
    logic [31:0] inst_o;
`ifdef FETCH_PERF_EN
    logic [31:0] fetched_cnt_o;
    logic [31:0] flushed_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    fetch_queue dut (
        .clk        (clk),
        .rst        (rst),
        .branch_i   (branch_i),
        .baddr_i    (baddr_i),
        .req_o      (req_o),
        .addr_o     (addr_o),
        .inst_i     (inst_i),
        .v_o        (v_o),
        .stall_i    (stall_i),
        .origaddr_o (origaddr_o),
        .inst_o     (inst_o)
`ifdef FETCH_PERF_EN
       ,.fetched_cnt_o (fetched_cnt_o),
        .flushed_cnt_o (flushed_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data equals the requested address.
    always @(posedge clk) inst_i <= req_o ? addr_o : 32'hDEAD_BEEF;

    initial begin
        #500000;
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL timeout: test sequence did not complete in time");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle, apply inputs, let combinational outputs settle.
    task automatic step(input logic s, input logic b, input logic [31:0] a);
        @(posedge clk);
        #1;
        stall_i  = s;
        branch_i = b;
        baddr_i  = a;
        #1;
    endtask

    // One reset edge, then release; returns inside the first fetch cycle.
    task automatic restart(input logic s);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        branch_i = 1'b0;
        baddr_i  = '0;
        stall_i  = s;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        logic        s;
        logic        b;
        logic [31:0] a;
        logic [31:0] exp_addr;
        int          ntx;

        rst = 1'b0; branch_i = 1'b0; baddr_i = '0; stall_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (v_o !== 1'b0) begin
            failures++;
            $error("FAIL reset_v observed=%0h expected=0", v_o);
        end
        checks++;
        if (req_o !== 1'b0) begin
            failures++;
            $error("FAIL reset_req observed=%0h expected=0", req_o);
        end

        // Streaming after reset release
        restart(1'b0);
        chk("s_c0_req", req_o === 1'b1, req_o, 1'b1);
        chk("s_c0_addr", addr_o === 32'h0, addr_o, 32'h0);
        chk("s_c0_v", v_o === 1'b0, v_o, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        chk("s_c1_addr", addr_o === 32'h4, addr_o, 32'h4);
        chk("s_c1_v", v_o === 1'b0, v_o, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        chk("s_c2_v", v_o === 1'b1, v_o, 1'b1);
        chk("s_c2_orig", origaddr_o === 32'h0, origaddr_o, 32'h0);
        chk("s_c2_inst", inst_o === 32'h0, inst_o, 32'h0);
        chk("s_c2_addr", addr_o === 32'h8, addr_o, 32'h8);
        step(1'b0, 1'b0, 32'h0);
        chk("s_c3_orig", origaddr_o === 32'h4, origaddr_o, 32'h4);
        chk("s_c3_inst", inst_o === 32'h4, inst_o, 32'h4);
        step(1'b0, 1'b0, 32'h0);
        chk("s_c4_orig", origaddr_o === 32'h8, origaddr_o, 32'h8);
        chk("s_c4_inst", inst_o === 32'h8, inst_o, 32'h8);

        // Stall fill then drain
        restart(1'b1);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("f_c3_req", req_o === 1'b1, req_o, 1'b1);
        step(1'b1, 1'b0, 32'h0);
        chk("f_c4_req", req_o === 1'b0, req_o, 1'b0);
        step(1'b1, 1'b0, 32'h0);
        chk("f_c5_req", req_o === 1'b0, req_o, 1'b0);
        chk("f_c5_orig", origaddr_o === 32'h0, origaddr_o, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("f_c6_orig", origaddr_o === 32'h0, origaddr_o, 32'h0);
        chk("f_c6_req", req_o === 1'b0, req_o, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        chk("f_c7_orig", origaddr_o === 32'h4, origaddr_o, 32'h4);
        chk("f_c7_addr", addr_o === 32'h10, addr_o, 32'h10);
        chk("f_c7_req", req_o === 1'b1, req_o, 1'b1);
        step(1'b0, 1'b0, 32'h0);
        chk("f_c8_orig", origaddr_o === 32'h8, origaddr_o, 32'h8);
        step(1'b0, 1'b0, 32'h0);
        chk("f_c9_orig", origaddr_o === 32'hC, origaddr_o, 32'hC);
        step(1'b0, 1'b0, 32'h0);
        chk("f_c10_orig", origaddr_o === 32'h10, origaddr_o, 32'h10);

        // Branch while stalled and full
        restart(1'b1);
        repeat (4) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h100);
        chk("bf_v_full", v_o === 1'b1, v_o, 1'b1);
        chk("bf_addr", addr_o === 32'h100, addr_o, 32'h100);
        chk("bf_req", req_o === 1'b1, req_o, 1'b1);
        step(1'b1, 1'b0, 32'h0);
        chk("bf_next_v", v_o === 1'b0, v_o, 1'b0);
        chk("bf_next_addr", addr_o === 32'h104, addr_o, 32'h104);
`ifdef FETCH_PERF_EN
        chk("bf_flushed", flushed_cnt_o === 32'd4, flushed_cnt_o, 32'd4);
`endif
        step(1'b0, 1'b0, 32'h0);
        chk("bf_head_v", v_o === 1'b1, v_o, 1'b1);
        chk("bf_head", origaddr_o === 32'h100, origaddr_o, 32'h100);
        chk("bf_head_inst", inst_o === 32'h100, inst_o, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        chk("bf_head2", origaddr_o === 32'h104, origaddr_o, 32'h104);

        // Branch with a request in flight, back-to-back branches, PC wrap
        restart(1'b0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h200);
        chk("bi_addr", addr_o === 32'h200, addr_o, 32'h200);
        chk("bi_pop_orig", origaddr_o === 32'h4, origaddr_o, 32'h4);
        step(1'b0, 1'b0, 32'h0);
        chk("bi_v0", v_o === 1'b0, v_o, 1'b0);
        chk("bi_addr2", addr_o === 32'h204, addr_o, 32'h204);
        step(1'b0, 1'b0, 32'h0);
        chk("bi_first", origaddr_o === 32'h200, origaddr_o, 32'h200);
        chk("bi_first_v", v_o === 1'b1, v_o, 1'b1);
        step(1'b0, 1'b1, 32'h500);
        chk("bb_pop_orig", origaddr_o === 32'h204, origaddr_o, 32'h204);
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        chk("bb_addr", addr_o === 32'hFFFF_FFF8, addr_o, 32'hFFFF_FFF8);
        chk("bb_v", v_o === 1'b0, v_o, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        chk("w_addr1", addr_o === 32'hFFFF_FFFC, addr_o, 32'hFFFF_FFFC);
        chk("w_v", v_o === 1'b0, v_o, 1'b0);
        step(1'b0, 1'b0, 32'h0);
        chk("w_addr2", addr_o === 32'h0, addr_o, 32'h0);
        chk("w_orig1", origaddr_o === 32'hFFFF_FFF8, origaddr_o, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 32'h0);
        chk("w_orig2", origaddr_o === 32'hFFFF_FFFC, origaddr_o, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("w_orig3", origaddr_o === 32'h0, origaddr_o, 32'h0);
        chk("w_inst3", inst_o === 32'h0, inst_o, 32'h0);

        // Reset mid-stream with three entries buffered
        restart(1'b0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("rm_c3_orig", origaddr_o === 32'h4, origaddr_o, 32'h4);
        step(1'b1, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rm_fetched", fetched_cnt_o === 32'd1, fetched_cnt_o, 32'd1);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rm_low_v", v_o === 1'b1, v_o, 1'b1);
        chk("rm_low_req", req_o === 1'b0, req_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        stall_i = 1'b0;
        #1;
        chk("rm_v0", v_o === 1'b0, v_o, 1'b0);
        chk("rm_addr", addr_o === 32'h0, addr_o, 32'h0);
        chk("rm_req", req_o === 1'b1, req_o, 1'b1);
`ifdef FETCH_PERF_EN
        chk("rm_fetched0", fetched_cnt_o === 32'd0, fetched_cnt_o, 32'd0);
`endif
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("rm_head", origaddr_o === 32'h0, origaddr_o, 32'h0);

        // Random stalls and occasional branches against a contiguity scoreboard
        restart(1'b0);
        exp_addr = 32'h0;
        ntx = 0;
        for (int i = 0; i < 1000; i++) begin
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 39) == 0);
            a = $urandom & 32'hFFFF_FFFC;
            step(s, b, a);
            if (v_o && !stall_i) begin
                chk("sb_orig", origaddr_o === exp_addr, origaddr_o, exp_addr);
                chk("sb_inst", inst_o === exp_addr, inst_o, exp_addr);
                exp_addr = exp_addr + 32'd4;
                ntx++;
            end
            if (branch_i) exp_addr = baddr_i;
        end
        chk("sb_progress", ntx > 300, ntx, 300);

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
